// File: rtl/wb_commit.sv
// Writeback commit: architectural GPR file + HI/LO with same-cycle bypass and a saturating commit counter.
// Reads are combinational (0 cycles), writes land at the next edge; the block never backpressures the pipeline.
module wb_commit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_wreg,
   input  logic [4:0]       wb_wd,
   input  logic [31:0]      wb_wdata,
   input  logic             hilo_en_i,
   input  logic [31:0]      hi_i,
   input  logic [31:0]      lo_i,
   input  logic             stall,
   input  logic             re1,
   input  logic [4:0]       raddr1,
   output logic [31:0]      rdata1,
   input  logic             re2,
   input  logic [4:0]       raddr2,
   output logic [31:0]      rdata2,
   output logic [31:0]      hi_o,
   output logic [31:0]      lo_o,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] commit_cnt
);

   logic [31:0] gpr [32];
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        wr_ok;
   logic        commit_ev;

   assign wr_ok     = wb_wreg && (wb_wd != 5'd0);
   assign commit_ev = (wr_ok || hilo_en_i) && !stall;

   // Writes ignore stall: MEM/WB holds its fields, so a held write just rewrites the same value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            gpr[i] <= 32'd0;
         end
      end else if (wr_ok) begin
         gpr[wb_wd] <= wb_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q <= 32'd0;
         lo_q <= 32'd0;
      end else if (hilo_en_i) begin
         hi_q <= hi_i;
         lo_q <= lo_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_cnt <= '0;
      end else if (cnt_clr) begin
         commit_cnt <= '0;
      end else if (commit_ev && (commit_cnt != {CNT_W{1'b1}})) begin
         commit_cnt <= commit_cnt + 1'b1;
      end
   end

   always_comb begin
      rdata1 = 32'd0;
      if (re1 && (raddr1 != 5'd0)) begin
         rdata1 = (wr_ok && (wb_wd == raddr1)) ? wb_wdata : gpr[raddr1];
      end
   end

   always_comb begin
      rdata2 = 32'd0;
      if (re2 && (raddr2 != 5'd0)) begin
         rdata2 = (wr_ok && (wb_wd == raddr2)) ? wb_wdata : gpr[raddr2];
      end
   end

   assign hi_o = hilo_en_i ? hi_i : hi_q;
   assign lo_o = hilo_en_i ? lo_i : lo_q;

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit (CNT_W=4): vector table plus reset, saturation and clear sequences.
module tb_wb_commit;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_wreg;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;
   logic        hilo_en_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        stall;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic        cnt_clr;
   logic [3:0]  commit_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   wb_commit #(.CNT_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_wreg    (wb_wreg),
      .wb_wd      (wb_wd),
      .wb_wdata   (wb_wdata),
      .hilo_en_i  (hilo_en_i),
      .hi_i       (hi_i),
      .lo_i       (lo_i),
      .stall      (stall),
      .re1        (re1),
      .raddr1     (raddr1),
      .rdata1     (rdata1),
      .re2        (re2),
      .raddr2     (raddr2),
      .rdata2     (rdata2),
      .hi_o       (hi_o),
      .lo_o       (lo_o),
      .cnt_clr    (cnt_clr),
      .commit_cnt (commit_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        hen;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        stl;
      logic        r1e;
      logic [4:0]  a1;
      logic        r2e;
      logic [4:0]  a2;
      logic        clr;
      logic [31:0] e1;
      logic [31:0] e2;
      logic [31:0] ehi;
      logic [31:0] elo;
      logic [3:0]  ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [3:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   vec_t tbl[17];

   function automatic vec_t mk(
      input logic wreg, input logic [4:0] wd, input logic [31:0] wdata,
      input logic hen, input logic [31:0] hi, input logic [31:0] lo, input logic stl,
      input logic r1e, input logic [4:0] a1, input logic r2e, input logic [4:0] a2,
      input logic clr, input logic [31:0] e1, input logic [31:0] e2,
      input logic [31:0] ehi, input logic [31:0] elo, input logic [3:0] ecnt);
      vec_t v;
      v.wreg = wreg; v.wd = wd; v.wdata = wdata; v.hen = hen; v.hi = hi; v.lo = lo;
      v.stl = stl; v.r1e = r1e; v.a1 = a1; v.r2e = r2e; v.a2 = a2; v.clr = clr;
      v.e1 = e1; v.e2 = e2; v.ehi = ehi; v.elo = elo; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      wb_wreg = 1'b0; wb_wd = 5'd0; wb_wdata = 32'd0;
      hilo_en_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
      stall = 1'b0; re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;
      cnt_clr = 1'b0;
   endtask

   // Called 1 time unit after a rising edge: drive, check combinational outputs, then the counter after the edge.
   task automatic run_vec(input string nm, input vec_t v);
      exp_t e;
      wb_wreg = v.wreg; wb_wd = v.wd; wb_wdata = v.wdata;
      hilo_en_i = v.hen; hi_i = v.hi; lo_i = v.lo; stall = v.stl;
      re1 = v.r1e; raddr1 = v.a1; re2 = v.r2e; raddr2 = v.a2; cnt_clr = v.clr;
      exp_q.push_back('{r1: v.e1, r2: v.e2, hi: v.ehi, lo: v.elo, cnt: v.ecnt});
      #2;
      e = exp_q.pop_front();
      chk({nm, ".rdata1"}, rdata1, e.r1);
      chk({nm, ".rdata2"}, rdata2, e.r2);
      chk({nm, ".hi_o"}, hi_o, e.hi);
      chk({nm, ".lo_o"}, lo_o, e.lo);
      @(posedge clk);
      #1;
      chk({nm, ".commit_cnt"}, {28'd0, commit_cnt}, {28'd0, e.cnt});
   endtask

   initial begin
      tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0, 0, 0, 1, 5,  1, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1);
      tbl[1]  = mk(0, 0,  0,            0, 0, 0, 0, 1, 5,  1, 5, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1);
      tbl[2]  = mk(1, 0,  32'h12345678, 0, 0, 0, 0, 1, 0,  1, 5, 0, 0, 32'hDEADBEEF, 0, 0, 1);
      tbl[3]  = mk(0, 0,  0,            0, 0, 0, 0, 1, 0,  0, 5, 0, 0, 0, 0, 0, 1);
      tbl[4]  = mk(1, 7,  32'h77777777, 1, 32'hAAAA0000, 32'h0000BBBB, 0, 1, 7, 1, 5, 0,
                   32'h77777777, 32'hDEADBEEF, 32'hAAAA0000, 32'h0000BBBB, 2);
      tbl[5]  = mk(0, 0,  0,            0, 0, 0, 0, 1, 7,  1, 7, 0,
                   32'h77777777, 32'h77777777, 32'hAAAA0000, 32'h0000BBBB, 2);
      tbl[6]  = mk(1, 5,  32'h55AA55AA, 0, 0, 0, 0, 1, 5,  1, 7, 0,
                   32'h55AA55AA, 32'h77777777, 32'hAAAA0000, 32'h0000BBBB, 3);
      tbl[7]  = mk(1, 9,  32'h99990000, 0, 0, 0, 1, 1, 9,  1, 9, 0,
                   32'h99990000, 32'h99990000, 32'hAAAA0000, 32'h0000BBBB, 3);
      tbl[8]  = tbl[7];
      tbl[9]  = tbl[7];
      tbl[10] = mk(1, 9,  32'h99990000, 0, 0, 0, 0, 1, 9,  1, 9, 0,
                   32'h99990000, 32'h99990000, 32'hAAAA0000, 32'h0000BBBB, 4);
      tbl[11] = mk(0, 0,  0,            0, 0, 0, 0, 1, 9,  1, 5, 0,
                   32'h99990000, 32'h55AA55AA, 32'hAAAA0000, 32'h0000BBBB, 4);
      tbl[12] = mk(0, 0,  0,            1, 1, 2, 1, 1, 9,  1, 5, 0,
                   32'h99990000, 32'h55AA55AA, 1, 2, 4);
      tbl[13] = mk(0, 0,  0,            0, 0, 0, 0, 1, 9,  1, 5, 0,
                   32'h99990000, 32'h55AA55AA, 1, 2, 4);
      tbl[14] = mk(1, 31, 32'hFFFFFFFF, 1, 3, 4, 0, 1, 31, 1, 0, 0, 32'hFFFFFFFF, 0, 3, 4, 5);
      tbl[15] = mk(1, 0,  32'h0BADF00D, 0, 0, 0, 0, 1, 31, 1, 0, 0, 32'hFFFFFFFF, 0, 3, 4, 5);
      tbl[16] = mk(0, 0,  0,            0, 0, 0, 0, 1, 31, 0, 31, 1, 32'hFFFFFFFF, 0, 3, 4, 0);

      drive_idle();
      rst = 1'b1;
      #1;
      chk("reset.commit_cnt", {28'd0, commit_cnt}, 32'd0);
      chk("reset.hi_o", hi_o, 32'd0);
      chk("reset.lo_o", lo_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         run_vec($sformatf("vec%0d", i), tbl[i]);
      end

      // Saturation: 20 events with CNT_W=4 must hold at 15.
      for (int i = 0; i < 20; i++) begin
         logic [31:0] d;
         d = 32'h1000 + i;
         run_vec($sformatf("sat%0d", i),
                 mk(1, 1, d, 0, 0, 0, 0, 1, 1, 1, 31, 0, d, 32'hFFFFFFFF, 3, 4,
                    (i >= 14) ? 4'd15 : 4'(i + 1)));
      end
      run_vec("clr_vs_event", mk(1, 2, 32'h2222, 1, 5, 6, 0, 1, 2, 1, 1, 1, 32'h2222, 32'h1013, 5, 6, 0));
      run_vec("after_clr", mk(1, 2, 32'h3333, 0, 0, 0, 0, 1, 2, 0, 1, 0, 32'h3333, 0, 5, 6, 1));

      // Async reset mid-cycle while a write to $3 is being presented.
      wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'hCAFEF00D;
      hilo_en_i = 1'b0; cnt_clr = 1'b0; re1 = 1'b0; re2 = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst.commit_cnt", {28'd0, commit_cnt}, 32'd0);
      chk("arst.hi_o", hi_o, 32'd0);
      chk("arst.lo_o", lo_o, 32'd0);
      wb_wreg = 1'b0;
      re1 = 1'b1; re2 = 1'b1;
      for (int a = 0; a < 32; a++) begin
         raddr1 = 5'(a);
         raddr2 = 5'(31 - a);
         #1;
         chk($sformatf("arst.rd1[%0d]", a), rdata1, 32'd0);
         chk($sformatf("arst.rd2[%0d]", 31 - a), rdata2, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      run_vec("post_rst_wr", mk(1, 3, 32'h0000ABCD, 0, 0, 0, 0, 1, 3, 1, 2, 0, 32'h0000ABCD, 0, 0, 0, 1));
      run_vec("post_rst_rd", mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3, 0, 32'h0000ABCD, 32'h0000ABCD, 0, 0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wb_commit.md
# wb_commit

Writeback commit unit at the far end of the MEM/WB pipeline register. It consumes the WB-stage GPR and HI/LO write fields, holds the architectural 32x32 general-purpose register file and the HI/LO pair, and serves two ID-stage read ports and a HI/LO read port. It bypasses same-cycle writes to readers and keeps a saturating commit counter for performance monitoring.

## Interface
- CNT_W, 32, width of the commit counter (1..32)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_wreg  in  1  GPR write enable from MEM/WB
- wb_wd  in  5  GPR write address
- wb_wdata  in  32  GPR write data
- hilo_en_i  in  1  HI/LO write enable from MEM/WB
- hi_i  in  32  HI write data
- lo_i  in  32  LO write data
- stall  in  1  WB stage held this cycle; same stall signal that drives MEM/WB
- re1  in  1  read-port-1 enable
- raddr1  in  5  read-port-1 address
- rdata1  out  32  read-port-1 data (combinational)
- re2  in  1  read-port-2 enable
- raddr2  in  5  read-port-2 address
- rdata2  out  32  read-port-2 data (combinational)
- hi_o  out  32  current HI value, bypassed (combinational)
- lo_o  out  32  current LO value, bypassed (combinational)
- cnt_clr  in  1  synchronous clear of the commit counter
- commit_cnt  out  CNT_W  number of committed writeback events, saturating

## Operation
- Reset (async, active-high): all 32 GPRs, HI, LO and commit_cnt go to 0 immediately, independent of clk. Read outputs then reflect 0 unless a bypass condition holds.
- A GPR write is qualified as wb_wreg=1 and wb_wd!=0. A qualified write stores wb_wdata into gpr[wb_wd] at the rising edge. Writes to $0 are dropped, and gpr[0] always reads 0.
- Writes are performed regardless of stall. MEM/WB holds its outputs under stall, so a repeated write of the same value is idempotent.
- Read port n (n=1,2) uses this priority order:
  - re_n=0 -> 0
  - raddr_n=0 -> 0
  - qualified write with wb_wd=raddr_n -> wb_wdata (bypass)
  - otherwise gpr[raddr_n]
- Both ports may read the same address, and both may bypass in the same cycle.
- HI/LO: when hilo_en_i=1, HI<=hi_i and LO<=lo_i at the edge. HI and LO are always written together, with no partial write. hi_o/lo_o = hilo_en_i ? hi_i/lo_i : stored HI/LO.
- Commit event: (qualified GPR write OR hilo_en_i) AND stall=0. A cycle with both a GPR write and a HI/LO write counts as one event.
- Counter update at the edge:
  - cnt_clr=1 -> 0. Clear wins over a simultaneous event.
  - otherwise on an event, increment by 1, holding at all-ones (2^CNT_W-1) once reached. No wrap.
- No internal state machine beyond storage. The block never stalls the pipeline.

## Timing
- Read latency: 0 cycles (combinational from raddr/re/wb_* to rdata).
- Write-to-storage: 1 edge. The value is visible from the bypass in the write cycle and from storage from the next cycle onward. There is no cycle in which a written value is invisible.
- HI/LO follow the same rule: bypass in the write cycle, storage after the edge.
- commit_cnt reflects events up to and including the previous edge, because it is a registered output.
- Reset asserted mid-write: the write is lost and state is 0. On the first edge after rst deasserts, normal writes resume.
- rdata1/rdata2/hi_o/lo_o have no combinational path from clk or cnt_clr.

## Test plan
- Reset: assert rst asynchronously between edges -> commit_cnt=0 at once. Read all 32 addresses with re=1 -> every rdata=0. hi_o=lo_o=0.
- Write/bypass: cycle 0 wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF, raddr1=raddr2=5, re1=re2=1 -> both rdata=0xDEADBEEF in cycle 0. Cycle 1 with wb_wreg=0 -> both still 0xDEADBEEF from storage.
- $0 and enable: write 0x12345678 to address 0, then read raddr1=0 -> 0 both in the write cycle and after. Set re2=0 with raddr2=5 -> rdata2=0.
- HI/LO: hilo_en_i=1, hi_i=0xAAAA0000, lo_i=0x0000BBBB -> hi_o/lo_o show these values the same cycle and persist after hilo_en_i=0. The event counts once even with a concurrent GPR write.
- Stall counting: hold a GPR write with stall=1 for 3 cycles, then stall=0 for 1 cycle -> commit_cnt increments by exactly 1 and register content is correct.
- Counter edges: with CNT_W=4, issue 20 events -> commit_cnt stays at 15. Then assert cnt_clr together with an event -> commit_cnt=0 the next cycle.
